// File: rtl/frame_mem_pkg.sv
// Shared types and helpers for the frame-buffer word memory.
// Holds the clear FSM encoding, read-during-write modes and byte merge.
package frame_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper supports; callers size-cast in and out.
    localparam int MERGE_W  = 512;
    localparam int MERGE_BE = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_mem_clr_seq.sv
// Clear sequencer: sweeps every address once, holding busy meanwhile.
// Starts after reset release (optional) or on a request while idle.
module frame_mem_clr_seq
    import frame_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= ST_IDLE;
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == ST_CLEAR);
    assign we_o   = busy_o;
    assign addr_o = cnt_q;

endmodule

// File: rtl/frame_mem_dp.sv
// Simple-dual-port frame-buffer memory with byte enables, 1/2-cycle
// registered reads, selectable read-during-write result and clear sweep.
module frame_mem_dp
    import frame_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 3,
    parameter int                    RD_LATENCY   = 1,
    parameter int                    RDW_MODE     = 0,
    parameter bit                    CLR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rdw_hit;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    frame_mem_clr_seq #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr_seq (
        .clk       (clk),
        .reset     (reset),
        .clr_req_i (clr_req),
        .busy_o    (busy),
        .addr_o    (clr_addr),
        .we_o      (clr_we)
    );

    assign wr_acc  = wr_en & ~busy;
    assign rd_acc  = rd_en & ~busy;
    assign rdw_hit = wr_acc && (wr_addr == rd_addr);

    assign wr_word = DATA_WIDTH'(byte_merge(
        MERGE_W'(mem_q[wr_addr]),
        MERGE_W'(wr_data),
        MERGE_BE'(wr_be)));

    // Bypass sees exactly the word the write port is about to store.
    assign rd_word = (RDW_MODE == RDW_NEW && rdw_hit)
                   ? wr_word : mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= CLR_VALUE;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  s1_vld_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_data_q  <= '0;
                s1_vld_q   <= 1'b0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                s1_vld_q   <= rd_acc;
                rd_valid_q <= s1_vld_q;
                if (rd_acc) begin
                    s1_data_q <= rd_word;
                end
                if (s1_vld_q) begin
                    rd_data_q <= s1_data_q;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= rd_word;
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: doc/frame_mem_dp.md
# frame_mem_dp

Parametrised simple-dual-port word memory for the frame buffer: one write port with byte enables, one read port with selectable 1- or 2-cycle registered latency and a `rd_valid` strobe. A built-in clear sequencer sweeps the whole array to a fixed value after reset or on request, with `busy` asserted throughout. It supersedes the plain fixed-latency data memory as the storage primitive under the frame-buffer read/write controllers.

## Interface
- `DATA_WIDTH`, 16: word width; must be a multiple of 8.
- `ADDR_WIDTH`, 3: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `RD_LATENCY`, 1: read latency in cycles; legal values 1 or 2.
- `RDW_MODE`, 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.
- `CLR_ON_RESET`, 1: 1 = run a clear sweep automatically after reset release.
- `CLR_VALUE`, 0: word written by the clear sweep.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clr_req`  in  1  one-cycle request to start a clear sweep.
- `busy`  out  1  clear sweep in progress.
- `wr_en`  in  1  active-high write enable.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_be`  in  DATA_WIDTH/8  byte enables; bit i gates bits [8i+7:8i].
- `rd_en`  in  1  active-high read enable.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_data`  out  DATA_WIDTH  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse marking fresh `rd_data`.

## Operation
- FSM states: IDLE and CLEAR. Reset state is CLEAR (clear counter = 0) if `CLR_ON_RESET`=1, else IDLE.
- CLEAR: each edge writes `CLR_VALUE` (all bytes) to the counter address, then increments the counter. After the edge that writes DEPTH-1: go to IDLE and deassert `busy`.
- IDLE: `clr_req`=1 moves to CLEAR with counter 0 on the next edge. `clr_req` in CLEAR is ignored; the sweep is not restarted.
- While `busy`=1:
  - `wr_en` and `rd_en` are ignored.
  - No `rd_valid` pulses are generated.
  - Reads already in the latency pipeline still complete.
- Write (IDLE, `wr_en`=1): only the enabled bytes are updated. `wr_be`=0 leaves the word unchanged.
- Read (IDLE, `rd_en`=1): the array is sampled at `rd_addr`.
- Same-address read and write on the same edge:
  - `RDW_MODE`=0 returns the pre-write word.
  - `RDW_MODE`=1 returns the old word with the enabled bytes replaced by `wr_data`.
- Read and write to different addresses on the same edge are independent.
- Reset values: `busy` = `CLR_ON_RESET`; `rd_data` = 0; `rd_valid` = 0; read pipeline cleared.
- The array itself is not reset; it is only initialised by the clear sweep.
- Reset asserted mid-sweep aborts the sweep. After release, the sweep restarts from address 0 if `CLR_ON_RESET`=1, else the block is IDLE with partially cleared contents.

## Timing
- Read accepted at edge N:
  - `RD_LATENCY`=1: `rd_data`/`rd_valid` update at edge N.
  - `RD_LATENCY`=2: `rd_data`/`rd_valid` update at edge N+1.
- Back-to-back reads: one result per cycle; `rd_valid` stays high for consecutive accepted reads.
- Write at edge N is visible to a read accepted at edge N+1 or later in either `RDW_MODE`.
- Clear sweep: `busy` is high for exactly DEPTH rising edges.
  - Auto sweep: counted from the first edge after reset release.
  - Requested sweep: counted from the edge after `clr_req` is sampled.
  - First normal access is accepted on the edge after `busy` falls.
- `clr_req` sampled together with `wr_en`/`rd_en` in IDLE: that write/read is performed, and the sweep starts on the next edge.

## Structure
- Package `frame_mem_pkg`:
  - FSM state encoding (IDLE, CLEAR).
  - `RDW_OLD`/`RDW_NEW` constants.
  - Byte-merge function used by both the write path and the RDW_NEW bypass.
- One sub-module `frame_mem_clr_seq`: clear FSM and address counter, outputting `busy`, sweep address and sweep write strobe.
- Top level: array, write/clear mux, read register(s), `RDW_MODE` bypass.

## Test plan
Defaults: DATA_WIDTH=16, ADDR_WIDTH=3, `CLR_VALUE`=0.
- Auto clear: hold `reset`=0, release, count edges → `busy`=1 for exactly 8 edges; then reads of addresses 0–7 → 16'h0000, one `rd_valid` pulse each.
- Byte enables: write 16'hA5C3 be=2'b11 to addr 2; then 16'hFF00 be=2'b01 to addr 2; read addr 2 → 16'hA500.
- Read-during-write: addr 4 holds 16'h1111; write 16'h2222 be=2'b11 and read addr 4 on the same edge → `RDW_MODE`=0 returns 16'h1111, `RDW_MODE`=1 returns 16'h2222; a read on the next cycle returns 16'h2222 in both modes.
- Latency: `RD_LATENCY`=2, reads of addr 1, 2, 3 on consecutive edges → `rd_valid` high for 3 cycles starting one edge later; data in order.
- Clear request: fill addresses with 16'hBEEF; pulse `clr_req`; during `busy`, attempt a write of 16'h1234 to addr 5 → ignored; after `busy` falls, addr 5 reads 16'h0000.
- Reset mid-sweep: assert `reset` at sweep address 3 → `rd_data`=0, `rd_valid`=0 immediately (asynchronous); after release, `busy` lasts a full 8 edges.
